inst_fetch_resp: RTL and testbench

- Instruction-side responder for the fetch stage. It accepts the fetch address `pc_i` and chip enable `ce_i` from the program counter register and fetches the 32-bit instruction word from a variable-latency instruction memory over a req/ack bus.
- It returns the instruction to the IF/ID stage and raises `stallreq_o` to ctrl while a fetch is outstanding.
- A one-entry last-fetch buffer serves repeated fetches of the same PC (stall replay) without a bus transaction.

---
 rtl/inst_fetch_resp.sv | 177 +++++++++++++++++
 tb/tb_inst_fetch_resp.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_resp.sv
// Fetch-stage instruction responder: fetches one word per request over a
// req/ack memory bus and replays the last fetched word without a bus cycle.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   pc_i, ce_i          fetch address / fetch enable from the PC register
//   flush_i             branch taken, in-flight fetch is stale
//   inst_o, pc_o        fetched word and its address
//   inst_valid_o        one-cycle pulse, inst_o valid for pc_o
//   addr_err_o          one-cycle pulse, misaligned PC
//   fetch_err_o         one-cycle pulse, bus timeout
//   stallreq_o          stall request to ctrl while a fetch is outstanding
//   mem_req, mem_addr   bus request (held until ack) and word address
//   mem_ack, mem_rdata  bus response strobe and read data
module inst_fetch_resp #(
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic [31:0] pc_o,
    output logic        stallreq_o,
    output logic        addr_err_o,
    output logic        fetch_err_o,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bv_q, bv_d;
    logic [31:0]   tag_q, tag_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   inst_q, inst_d;
    logic [31:0]   pc_q, pc_d;
    logic          iv_q, iv_d;
    logic          ae_q, ae_d;
    logic          fe_q, fe_d;
    logic          stall;

    logic aligned;
    logic hit;
    logic tmo;

    assign aligned = (pc_i[1:0] == 2'b00);
    assign hit     = bv_q && (tag_q == pc_i);
    assign tmo     = (cnt_q == CW'(TIMEOUT - 1)) && !mem_ack;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        bv_d    = bv_q;
        tag_d   = tag_q;
        data_d  = data_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        iv_d    = 1'b0;
        ae_d    = 1'b0;
        fe_d    = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ce_i) begin
                    if (!aligned) begin
                        ae_d   = 1'b1;
                        inst_d = NOP_INST;
                        pc_d   = pc_i;
                    end else if (hit) begin
                        iv_d   = 1'b1;
                        inst_d = data_q;
                        pc_d   = tag_q;
                    end else begin
                        stall   = 1'b1;
                        req_d   = 1'b1;
                        addr_d  = pc_i;
                        cnt_d   = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT, DRAIN: begin
                if (mem_ack) begin
                    // Data is cached even when stale: a flushed fetch
                    // is often refetched shortly after.
                    req_d   = 1'b0;
                    bv_d    = 1'b1;
                    tag_d   = addr_q;
                    data_d  = mem_rdata;
                    state_d = IDLE;
                    if (state_q == WAIT && !flush_i) begin
                        iv_d   = 1'b1;
                        inst_d = mem_rdata;
                        pc_d   = addr_q;
                    end
                end else if (tmo) begin
                    req_d   = 1'b0;
                    bv_d    = 1'b0;
                    fe_d    = 1'b1;
                    inst_d  = NOP_INST;
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    // The bus cycle cannot be cancelled, so a flush
                    // only suppresses the result.
                    if (state_q == WAIT && flush_i) begin
                        state_d = DRAIN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
            bv_q    <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            inst_q  <= NOP_INST;
            pc_q    <= '0;
            iv_q    <= 1'b0;
            ae_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            bv_q    <= bv_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            iv_q    <= iv_d;
            ae_q    <= ae_d;
            fe_q    <= fe_d;
        end
    end

    // Gate the combinational stall so it also drops at once in reset.
    assign stallreq_o   = stall && rst;
    assign inst_o       = inst_q;
    assign pc_o         = pc_q;
    assign inst_valid_o = iv_q;
    assign addr_err_o   = ae_q;
    assign fetch_err_o  = fe_q;
    assign mem_req      = req_q;
    assign mem_addr     = addr_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Testbench for inst_fetch_resp: scenario tasks push expected pulses to a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_inst_fetch_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_i = '0;
    logic        ce_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic [31:0] pc_o;
    logic        stallreq_o;
    logic        addr_err_o;
    logic        fetch_err_o;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_AERR  = 3'b010;
    localparam logic [2:0] K_FERR  = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    inst_fetch_resp #(.TIMEOUT(16), .NOP_INST(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .flush_i      (flush_i),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o),
        .pc_o         (pc_o),
        .stallreq_o   (stallreq_o),
        .addr_err_o   (addr_err_o),
        .fetch_err_o  (fetch_err_o),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [2:0] k, input logic [31:0] i,
                        input logic [31:0] p);
        exp_t x;
        x.kind = k;
        x.inst = i;
        x.pc   = p;
        sb.push_back(x);
    endtask

    always @(negedge clk) begin
        if (rst && (inst_valid_o || addr_err_o || fetch_err_o)) begin
            check("pulse_excl",
                  32'(inst_valid_o) + 32'(addr_err_o) + 32'(fetch_err_o), 1);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", {inst_valid_o, addr_err_o, fetch_err_o},
                      e.kind);
                check("inst_o", inst_o, e.inst);
                if (e.kind != K_FERR) check("pc_o", pc_o, e.pc);
            end
        end
    end

    // Miss fetch; memory acks lat cycles after mem_req appears.
    // flush_cyc selects the WAIT cycle with flush_i (0 = none).
    task automatic fetch_mem(input logic [31:0] pc, input logic [31:0] data,
                             input int lat, input int flush_cyc);
        tick();
        pc_i = pc;
        ce_i = 1'b1;
        #1;
        check("miss_stall", stallreq_o, 1);
        check("miss_noreq_yet", mem_req, 0);
        tick();
        ce_i = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            flush_i = (k == flush_cyc);
            #1;
            check("wait_req", mem_req, 1);
            check("wait_stall", stallreq_o, 1);
            if (k == 1) check("wait_addr", mem_addr, pc);
            tick();
        end
        flush_i   = (flush_cyc == lat + 1);
        mem_ack   = 1'b1;
        mem_rdata = data;
        #1;
        if (flush_cyc == 0) begin
            check("ack_stall", stallreq_o, 0);
            push(K_VALID, data, pc);
        end
        tick();
        mem_ack   = 1'b0;
        flush_i   = 1'b0;
        mem_rdata = '0;
        #1;
        check("ack_dropreq", mem_req, 0);
    endtask

    task automatic hit_fetch(input logic [31:0] pc, input logic [31:0] data);
        tick();
        pc_i = pc;
        ce_i = 1'b1;
        #1;
        check("hit_stall", stallreq_o, 0);
        push(K_VALID, data, pc);
        tick();
        ce_i = 1'b0;
        #1;
        check("hit_noreq", mem_req, 0);
    endtask

    task automatic misaligned(input logic [31:0] pc);
        tick();
        pc_i = pc;
        ce_i = 1'b1;
        #1;
        check("mis_stall", stallreq_o, 0);
        push(K_AERR, 32'h0, pc);
        tick();
        ce_i = 1'b0;
        #1;
        check("mis_noreq", mem_req, 0);
    endtask

    task automatic timeout_fetch(input logic [31:0] pc);
        int req_cyc;
        req_cyc = 0;
        tick();
        pc_i = pc;
        ce_i = 1'b1;
        tick();
        ce_i = 1'b0;
        push(K_FERR, 32'h0, pc);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!mem_req) break;
            req_cyc++;
            check("to_stall", stallreq_o, (req_cyc == 16) ? 0 : 1);
            tick();
        end
        check("to_req_cycles", req_cyc, 16);
    endtask

    initial begin
        #1;
        check("rst_inst", inst_o, 32'h0);
        check("rst_req", mem_req, 0);
        check("rst_stall", stallreq_o, 0);
        check("rst_pulses", {inst_valid_o, addr_err_o, fetch_err_o}, 0);
        tick();
        tick();
        rst = 1'b1;

        fetch_mem(32'h0000_0000, 32'h3401_0020, 3, 0);
        hit_fetch(32'h0000_0000, 32'h3401_0020);
        misaligned(32'h0000_0006);

        fetch_mem(32'h0000_0010, 32'hA5A5_0010, 4, 2);
        hit_fetch(32'h0000_0010, 32'hA5A5_0010);

        fetch_mem(32'h0000_0050, 32'h1234_0050, 1, 2);
        hit_fetch(32'h0000_0050, 32'h1234_0050);

        timeout_fetch(32'h0000_0020);
        fetch_mem(32'h0000_0020, 32'h0BAD_F00D, 2, 0);

        fetch_mem(32'hFFFF_FFFC, 32'hCAFE_FFFC, 1, 0);
        fetch_mem(32'h0000_0000, 32'h3401_0020, 2, 0);

        tick();
        pc_i = 32'h0000_0040;
        ce_i = 1'b1;
        tick();
        ce_i = 1'b0;
        tick();
        #1;
        check("pre_rst_req", mem_req, 1);
        rst = 1'b0;
        #1;
        check("async_rst_req", mem_req, 0);
        check("async_rst_stall", stallreq_o, 0);
        check("async_rst_pulses",
              {inst_valid_o, addr_err_o, fetch_err_o}, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        #1;
        check("late_ack_noreq", mem_req, 0);
        tick();
        fetch_mem(32'h0000_0040, 32'h0040_0040, 1, 0);

        tick();
        tick();
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
